// File: rtl/dct_block_loader.sv
//------------------------------------------------------------------------------
// Module  : dct_block_loader
// Purpose : Serial raster pixels -> fixed-point 8x8 block, double-buffered,
//           presented in parallel to the a0..a63 inputs of the DCT2D core.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dct_block_loader #(
  parameter int PIX_W       = 8,
  parameter int DATA_W      = 24,
  parameter int FRAC_BITS   = 8,
  parameter int LEVEL_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIX_W-1:0]       in_pix,
  input  logic                   in_valid,
  input  logic                   in_sob,
  output logic                   in_ready,
  output logic [64*DATA_W-1:0]   out_block,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sob_err
);

  localparam int INT_W = DATA_W - FRAC_BITS;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t       state [2];
  logic [DATA_W-1:0] mem [2][64];
  logic [5:0]        wr_ptr;
  logic              fill_bank;
  logic              out_bank;

  logic [INT_W-1:0]  int_part;
  logic [DATA_W-1:0] sample;
  logic              accept;
  logic              restart;
  logic              complete;
  logic              handshake;
  logic [5:0]        wr_idx;

  // Pixel to fixed point: integer part either zero-extended or centred
  // around zero, then moved above the fractional bits.
  generate
    if (LEVEL_SHIFT != 0) begin : g_level_shift
      localparam logic [PIX_W:0] HALF = {2'b01, {(PIX_W-1){1'b0}}};
      logic [PIX_W:0] centered;
      assign centered = {1'b0, in_pix} - HALF;
      assign int_part = INT_W'($signed(centered));
    end else begin : g_zero_ext
      assign int_part = INT_W'(in_pix);
    end
  endgenerate

  assign sample = DATA_W'(int_part) << FRAC_BITS;

  // Handshake qualifiers. A start-of-block mid-block restarts the bank at
  // index 0, so it can never also be the completing write.
  assign in_ready  = !reset && (state[fill_bank] != FULL);
  assign accept    = in_valid && in_ready;
  assign restart   = accept && in_sob && (wr_ptr != 6'd0);
  assign complete  = accept && !restart && (wr_ptr == 6'd63);
  assign handshake = out_valid && out_ready;
  assign wr_idx    = restart ? 6'd0 : wr_ptr;

  // Sample storage; the fill bank is never FULL while written, so the
  // presented bank is untouched until it is consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[fill_bank][wr_idx] <= sample;
    end
  end

  // Bank bookkeeping, write pointer and output presentation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state[0]  <= EMPTY;
      state[1]  <= EMPTY;
      wr_ptr    <= 6'd0;
      fill_bank <= 1'b0;
      out_bank  <= 1'b0;
      out_valid <= 1'b0;
      sob_err   <= 1'b0;
    end else begin
      sob_err <= 1'b0;

      if (accept) begin
        if (restart) begin
          wr_ptr           <= 6'd1;
          state[fill_bank] <= FILLING;
          sob_err          <= 1'b1;
        end else if (complete) begin
          wr_ptr           <= 6'd0;
          state[fill_bank] <= FULL;
          fill_bank        <= !fill_bank;
        end else begin
          wr_ptr           <= wr_ptr + 6'd1;
          state[fill_bank] <= FILLING;
        end
      end

      if (handshake) begin
        // Move to the other bank; keep presenting if it is already full or
        // completes on this very edge.
        state[out_bank] <= EMPTY;
        out_bank        <= !out_bank;
        out_valid       <= (state[!out_bank] == FULL) ||
                           (complete && (fill_bank != out_bank));
      end else if (!out_valid && complete) begin
        out_bank  <= fill_bank;
        out_valid <= 1'b1;
      end
    end
  end

  // Parallel read of the presented bank; zero whenever nothing is presented.
  generate
    for (genvar k = 0; k < 64; k++) begin : g_out
      assign out_block[k*DATA_W +: DATA_W] = out_valid ? mem[out_bank][k] : '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dct_block_loader.sv
//------------------------------------------------------------------------------
// Module  : tb_dct_block_loader
// Purpose : Self-checking bench for dct_block_loader (both level-shift modes).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dct_block_loader;

  localparam int DW = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_pix;
  logic              in_valid;
  logic              in_sob;
  logic              out_ready;
  logic              in_ready,  in_ready_ls;
  logic              out_valid, out_valid_ls;
  logic              sob_err,   sob_err_ls;
  logic [64*DW-1:0]  blk0, blk1;

  dct_block_loader #(.PIX_W(8), .DATA_W(DW), .FRAC_BITS(8), .LEVEL_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .in_pix(in_pix), .in_valid(in_valid), .in_sob(in_sob),
    .in_ready(in_ready), .out_block(blk0), .out_valid(out_valid),
    .out_ready(out_ready), .sob_err(sob_err));

  dct_block_loader #(.PIX_W(8), .DATA_W(DW), .FRAC_BITS(8), .LEVEL_SHIFT(1)) dut_ls (
    .clk(clk), .reset(reset), .in_pix(in_pix), .in_valid(in_valid), .in_sob(in_sob),
    .in_ready(in_ready_ls), .out_block(blk1), .out_valid(out_valid_ls),
    .out_ready(out_ready), .sob_err(sob_err_ls));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pix;
    logic [23:0] e0;
    logic [23:0] e1;
  } vec_t;

  vec_t        tbl [8];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];
  int          cnt         = 0;
  int          blocks_seen = 0;
  int          ready_drops = 0;
  int          sob_pulses  = 0;
  bit          watch_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] conv0(input logic [7:0] p);
    return {8'h00, p, 8'h00};
  endfunction

  function automatic logic [23:0] conv1(input logic [7:0] p);
    return 24'((int'(p) - 128) * 256);
  endfunction

  function automatic logic [23:0] word(input logic [64*DW-1:0] b, input int k);
    return b[k*DW +: DW];
  endfunction

  // Scoreboard: compare the presented block against the queued expectations
  // on the cycle it is consumed.
  task automatic check_block();
    logic [23:0] e0, e1;
    int bad0, bad1;
    bad0 = 0;
    bad1 = 0;
    if (q0.size() < 64 || q1.size() < 64) begin
      n_checks++;
      n_fail++;
      $display("FAIL block_queue: got %0d queued expected at least 64", q0.size());
      q0.delete();
      q1.delete();
      return;
    end
    for (int k = 0; k < 64; k++) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      if (word(blk0, k) !== e0) begin
        if (bad0 == 0)
          $display("FAIL block%0d_ls0 word %0d: got %h expected %h", blocks_seen, k, word(blk0, k), e0);
        bad0++;
      end
      if (word(blk1, k) !== e1) begin
        if (bad1 == 0)
          $display("FAIL block%0d_ls1 word %0d: got %h expected %h", blocks_seen, k, word(blk1, k), e1);
        bad1++;
      end
    end
    n_checks += 2;
    if (bad0 != 0) n_fail++;
    if (bad1 != 0) n_fail++;
    check("out_valid_ls", 64'(out_valid_ls), 64'd1);
    blocks_seen++;
  endtask

  // Monitor on the falling edge: out_ready only changes just after a rising
  // edge, so valid&ready here means the block is taken on the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) check_block();
    if (watch_ready && !in_ready) ready_drops++;
    if (!reset && sob_err) sob_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sob   = 1'b0;
  endtask

  // Drive one pixel until accepted; update the model on acceptance.
  task automatic send(input logic [7:0] p, input logic sob, input logic [23:0] e0, input logic [23:0] e1);
    logic ok;
    in_pix   = p;
    in_sob   = sob;
    in_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) begin
        if (sob && cnt != 0) begin
          repeat (cnt) begin
            void'(q0.pop_back());
            void'(q1.pop_back());
          end
          cnt = 1;
        end else begin
          cnt = (cnt + 1) % 64;
        end
        q0.push_back(e0);
        q1.push_back(e1);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: got in_ready=0 for 2000 cycles expected accept");
  endtask

  task automatic send_px(input logic [7:0] p, input logic sob);
    send(p, sob, conv0(p), conv1(p));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int bad;
    tbl[0] = '{8'd0,   24'h000000, 24'hFF8000};
    tbl[1] = '{8'd1,   24'h000100, 24'hFF8100};
    tbl[2] = '{8'd127, 24'h007F00, 24'hFFFF00};
    tbl[3] = '{8'd128, 24'h008000, 24'h000000};
    tbl[4] = '{8'd129, 24'h008100, 24'h000100};
    tbl[5] = '{8'd130, 24'h008200, 24'h000200};
    tbl[6] = '{8'd200, 24'h00C800, 24'h004800};
    tbl[7] = '{8'd255, 24'h00FF00, 24'h007F00};

    reset     = 1'b1;
    in_pix    = 8'd0;
    idle();
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sob_err",   64'(sob_err),   64'd0);
    check("rst_out_block", 64'(|blk0),     64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 1: constant 130, consumer always ready, latency and one-cycle consume
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 63; k++) send_px(8'd130, k == 0);
    check("t1_valid_before_64th", 64'(out_valid), 64'd0);
    send_px(8'd130, 1'b0);
    check("t1_valid_after_64th", 64'(out_valid), 64'd1);
    check("t1_word0", 64'(word(blk0, 0)), 64'h008200);
    idle();
    tick();
    check("t1_consumed", 64'(out_valid), 64'd0);
    check("t1_blocks", 64'(blocks_seen), 64'd1);

    // 2: ramp with consumer stalled, both banks fill, input stalls
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) send_px(8'(k), 1'b0);
    for (int k = 0; k < 64; k++) send_px(8'(255 - k), 1'b0);
    check("t2_in_ready_full", 64'(in_ready), 64'd0);
    check("t2_valid", 64'(out_valid), 64'd1);
    idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bad = 0;
      for (int k = 0; k < 64; k++) if (word(blk0, k) !== 24'(k << 8)) bad++;
      check("t2_stall_block_bad_words", 64'(bad), 64'd0);
      check("t2_stall_in_ready", 64'(in_ready), 64'd0);
      check("t2_stall_valid", 64'(out_valid), 64'd1);
    end
    tick();
    out_ready = 1'b1;
    tick();
    check("t2_second_presented", 64'(out_valid), 64'd1);
    check("t2_in_ready_freed", 64'(in_ready), 64'd1);
    tick();
    check("t2_drained", 64'(out_valid), 64'd0);
    check("t2_blocks", 64'(blocks_seen), 64'd3);

    // 3: back-to-back blocks with continuous valid/ready
    base = blocks_seen;
    watch_ready = 1'b1;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 64; k++) send_px(8'(k * 3 + b * 17), k == 0);
    idle();
    watch_ready = 1'b0;
    repeat (3) tick();
    check("t3_in_ready_drops", 64'(ready_drops), 64'd0);
    check("t3_blocks", 64'(blocks_seen - base), 64'd3);

    // 3b: completion and consumption on the same edge, no bubble
    out_ready = 1'b0;
    base = blocks_seen;
    for (int k = 0; k < 64; k++) send_px(8'(k + 9), 1'b0);
    for (int k = 0; k < 63; k++) send_px(8'(200 - k), 1'b0);
    out_ready = 1'b1;
    send_px(8'd42, 1'b0);
    check("t3b_no_bubble_valid", 64'(out_valid), 64'd1);
    check("t3b_in_ready", 64'(in_ready), 64'd1);
    idle();
    tick();
    check("t3b_drained", 64'(out_valid), 64'd0);
    check("t3b_blocks", 64'(blocks_seen - base), 64'd2);

    // 4: mid-block start-of-block discards the partial block
    base = sob_pulses;
    for (int k = 0; k < 20; k++) send_px(8'(50 + k), k == 0);
    send_px(8'd7, 1'b1);
    check("t4_sob_err_pulse", 64'(sob_err), 64'd1);
    send_px(8'd100, 1'b0);
    check("t4_sob_err_clear", 64'(sob_err), 64'd0);
    for (int k = 1; k < 62; k++) send_px(8'(100 + k), 1'b0);
    check("t4_not_yet_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    send_px(8'd163, 1'b0);
    check("t4_valid", 64'(out_valid), 64'd1);
    check("t4_word0", 64'(word(blk0, 0)), 64'h000700);
    check("t4_word1", 64'(word(blk0, 1)), 64'h006400);
    idle();
    check("t4_sob_pulses", 64'(sob_pulses - base), 64'd1);
    tick();
    out_ready = 1'b1;
    tick();

    // 5: conversion table, both level-shift settings
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) send(tbl[k % 8].pix, 1'b0, tbl[k % 8].e0, tbl[k % 8].e1);
    idle();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_ls0_pix%0d", tbl[i].pix), 64'(word(blk0, i)), 64'(tbl[i].e0));
      check($sformatf("t5_ls1_pix%0d", tbl[i].pix), 64'(word(blk1, i)), 64'(tbl[i].e1));
    end
    tick();
    out_ready = 1'b1;
    tick();
    check("t5_drained", 64'(out_valid), 64'd0);

    // 6: asynchronous reset while a block is presented and another is filling
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) send_px(8'(k ^ 8'h33), 1'b0);
    for (int k = 0; k < 40; k++) send_px(8'(k + 1), 1'b0);
    idle();
    @(negedge clk);
    check("t6_pre_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_valid_ls", 64'(out_valid_ls), 64'd0);
    check("t6_rst_block", 64'(|blk0), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    q0.delete();
    q1.delete();
    cnt = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    base = blocks_seen;
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) send_px(8'(k ^ 8'h5A), 1'b0);
    idle();
    repeat (3) tick();
    check("t6_fresh_block", 64'(blocks_seen - base), 64'd1);
    check("final_queue_empty", 64'(q0.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
